// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates conditional branches, JAL and JALR,
// trains a 2-bit BHT, flags mispredictions and keeps saturating event counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int PIPE      = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [9:0]       opfunct,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             stall,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic             out_valid,
  output logic             taken,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = opfunct[6:0];
  assign funct3 = opfunct[9:7];

  logic            d_cond, d_ctrl, d_illegal, d_taken;
  logic [XLEN-1:0] d_target, d_redirect, jalr_sum;
  logic [IDX_W-1:0] d_idx;

  assign jalr_sum = rs1_val + imm;
  assign d_idx    = pc[IDX_W+1:2];

  always_comb begin
    d_cond    = 1'b0;
    d_ctrl    = 1'b0;
    d_illegal = 1'b0;
    d_taken   = 1'b0;
    d_target  = pc + imm;
    case (opcode)
      OP_BRANCH: begin
        d_cond = 1'b1;
        d_ctrl = 1'b1;
        case (funct3)
          3'b000:  d_taken = (rs1_val == rs2_val);
          3'b001:  d_taken = (rs1_val != rs2_val);
          3'b100:  d_taken = ($signed(rs1_val) <  $signed(rs2_val));
          3'b101:  d_taken = ($signed(rs1_val) >= $signed(rs2_val));
          3'b110:  d_taken = (rs1_val <  rs2_val);
          3'b111:  d_taken = (rs1_val >= rs2_val);
          default: begin
            d_cond    = 1'b0;
            d_ctrl    = 1'b0;
            d_illegal = 1'b1;
          end
        endcase
      end
      OP_JAL: begin
        d_ctrl  = 1'b1;
        d_taken = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          d_ctrl   = 1'b1;
          d_taken  = 1'b1;
          d_target = {jalr_sum[XLEN-1:1], 1'b0};
        end
      end
      default: ;
    endcase
    d_redirect = d_taken ? d_target : pc + XLEN'(4);
  end

  // Resolve-stage view: either the registered instruction or the live input
  logic             s_valid, s_taken, s_pred, s_illegal, s_ctrl, s_cond;
  logic [IDX_W-1:0] s_idx;
  logic             update_en;

  assign flush     = s_valid & (s_taken != s_pred) & ~stall;
  assign update_en = s_valid & ~stall;

  generate
    if (PIPE != 0) begin : g_pipe
      logic             valid_reg, taken_reg, pred_reg, illegal_reg, ctrl_reg, cond_reg;
      logic [IDX_W-1:0] idx_reg;
      logic [XLEN-1:0]  redirect_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg    <= 1'b0;
          taken_reg    <= 1'b0;
          pred_reg     <= 1'b0;
          illegal_reg  <= 1'b0;
          ctrl_reg     <= 1'b0;
          cond_reg     <= 1'b0;
          idx_reg      <= '0;
          redirect_reg <= '0;
        end else if (!stall) begin
          // an instruction arriving alongside a flush is on the wrong path
          valid_reg <= in_valid & ~flush;
          if (in_valid & ~flush) begin
            taken_reg    <= d_taken;
            pred_reg     <= pred_taken;
            illegal_reg  <= d_illegal;
            ctrl_reg     <= d_ctrl;
            cond_reg     <= d_cond;
            idx_reg      <= d_idx;
            redirect_reg <= d_redirect;
          end
        end
      end

      assign s_valid     = valid_reg;
      assign s_taken     = taken_reg;
      assign s_pred      = pred_reg;
      assign s_illegal   = illegal_reg;
      assign s_ctrl      = ctrl_reg;
      assign s_cond      = cond_reg;
      assign s_idx       = idx_reg;
      assign redirect_pc = redirect_reg;
    end else begin : g_comb
      logic [XLEN-1:0] hold_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          hold_reg <= '0;
        else if (flush)
          hold_reg <= d_redirect;
      end

      assign s_valid     = in_valid & ~stall & rst_n;
      assign s_taken     = d_taken;
      assign s_pred      = pred_taken;
      assign s_illegal   = d_illegal;
      assign s_ctrl      = d_ctrl;
      assign s_cond      = d_cond;
      assign s_idx       = d_idx;
      assign redirect_pc = flush ? d_redirect : hold_reg;
    end
  endgenerate

  assign out_valid  = s_valid;
  assign taken      = s_valid & s_taken;
  assign illegal_br = s_valid & s_illegal;

  // Branch history table; reads see the value before this cycle's update
  logic [1:0] bht [BHT_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= 2'b01;
    end else if (update_en && s_cond) begin
      if (s_taken) begin
        if (bht[s_idx] != 2'b11)
          bht[s_idx] <= bht[s_idx] + 2'd1;
      end else begin
        if (bht[s_idx] != 2'b00)
          bht[s_idx] <= bht[s_idx] - 2'd1;
      end
    end
  end

  assign lookup_taken = bht[lookup_pc[IDX_W+1:2]][1];

  logic lookup_unused;
  assign lookup_unused = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  logic [CNT_W-1:0] br_count_reg, mispred_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_reg      <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (update_en && s_ctrl && !(&br_count_reg))
        br_count_reg <= br_count_reg + CNT_W'(1);
      if (flush && !(&mispred_count_reg))
        mispred_count_reg <= mispred_count_reg + CNT_W'(1);
    end
  end

  assign br_count      = br_count_reg;
  assign mispred_count = mispred_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic compared against an instruction-level reference model.
module tb_branch_resolve_unit;

  localparam logic [6:0] OPB  = 7'b1100011;
  localparam logic [6:0] OPJ  = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111;
  localparam logic [6:0] OPAL = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [9:0]  opfunct = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0, lookup_pc = '0;
  logic        pred_taken = 1'b0;
  logic        stall = 1'b0;

  logic        lookup_taken, out_valid, taken, flush, illegal_br;
  logic [31:0] redirect_pc;
  logic [15:0] br_count, mispred_count;

  logic        s_lookup_taken, s_out_valid, s_taken, s_flush, s_illegal_br;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_br_count, s_mispred_count;

  always #5 clk = ~clk;

  branch_resolve_unit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opfunct(opfunct),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .stall(stall), .lookup_pc(lookup_pc),
    .lookup_taken(lookup_taken), .out_valid(out_valid), .taken(taken),
    .redirect_pc(redirect_pc), .flush(flush), .illegal_br(illegal_br),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  // narrow-counter copy on the same stimulus, to reach saturation quickly
  branch_resolve_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opfunct(opfunct),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .pc(pc), .imm(imm),
    .pred_taken(pred_taken), .stall(stall), .lookup_pc(lookup_pc),
    .lookup_taken(s_lookup_taken), .out_valid(s_out_valid), .taken(s_taken),
    .redirect_pc(s_redirect_pc), .flush(s_flush), .illegal_br(s_illegal_br),
    .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one pending instruction, BHT as integers, event tallies
  bit          m_valid, m_taken, m_pred, m_ill, m_ctrl, m_cond;
  logic [31:0] m_redir;
  int          m_idx;
  int          bht_m [16];
  int          br_n, mis_n;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void ref_resolve(input logic [9:0] of, input logic [31:0] a, b, p, im,
                                      output bit ctrl, cond, ill, tk, output logic [31:0] redir);
    logic [6:0]  op;
    int          f3;
    logic [31:0] tgt;
    op = of[6:0];
    f3 = int'(of[9:7]);
    ctrl = 0; cond = 0; ill = 0; tk = 0;
    tgt = p + im;
    if (op == OPB) begin
      if (f3 == 2 || f3 == 3) ill = 1;
      else begin
        ctrl = 1; cond = 1;
        case (f3)
          0: tk = (a == b);
          1: tk = (a != b);
          4: tk = ($signed(a) < $signed(b));
          5: tk = !($signed(a) < $signed(b));
          6: tk = (a < b);
          default: tk = !(a < b);
        endcase
      end
    end else if (op == OPJ) begin
      ctrl = 1; tk = 1;
    end else if (op == OPJR && f3 == 0) begin
      ctrl = 1; tk = 1;
      tgt = (a + im) & 32'hFFFF_FFFE;
    end
    redir = tk ? tgt : p + 32'd4;
  endfunction

  function automatic bit exp_flush();
    return m_valid && (m_taken != m_pred) && !stall;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_taken = 0; m_pred = 0; m_ill = 0; m_ctrl = 0; m_cond = 0;
    m_redir = '0; m_idx = 0; br_n = 0; mis_n = 0;
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
  endtask

  task automatic drive(input bit v, input logic [9:0] of, input logic [31:0] a, b, p, im,
                       input bit pt, input bit st, input logic [31:0] lp);
    in_valid = v; opfunct = of; rs1_val = a; rs2_val = b; pc = p; imm = im;
    pred_taken = pt; stall = st; lookup_pc = lp;
  endtask

  task automatic idle(input logic [31:0] lp);
    drive(0, '0, '0, '0, '0, '0, 0, 0, lp);
  endtask

  task automatic sample();
    bit ef;
    bit lk;
    @(negedge clk);
    ef = exp_flush();
    lk = (bht_m[int'(lookup_pc[5:2])] >= 2);
    check_val("out_valid", out_valid, m_valid);
    check_val("taken", taken, m_valid && m_taken);
    check_val("illegal_br", illegal_br, m_valid && m_ill);
    check_val("flush", flush, ef);
    if (ef) check_val("redirect_pc", redirect_pc, m_redir);
    check_val("br_count", br_count, satv(br_n, 65535));
    check_val("mispred_count", mispred_count, satv(mis_n, 65535));
    check_val("lookup_taken", lookup_taken, lk);
    check_val("sat_out_valid", s_out_valid, m_valid);
    check_val("sat_flush", s_flush, ef);
    check_val("sat_taken", s_taken, m_valid && m_taken);
    check_val("sat_illegal", s_illegal_br, m_valid && m_ill);
    check_val("sat_lookup", s_lookup_taken, lk);
    if (ef) check_val("sat_redirect", s_redirect_pc, m_redir);
    check_val("sat_br_count", s_br_count, satv(br_n, 15));
    check_val("sat_mispred_count", s_mispred_count, satv(mis_n, 15));
  endtask

  task automatic advance();
    bit ef;
    ef = exp_flush();
    if (!stall && m_valid) begin
      if (m_cond) bht_m[m_idx] = m_taken ? satv(bht_m[m_idx] + 1, 3)
                                         : ((bht_m[m_idx] > 0) ? bht_m[m_idx] - 1 : 0);
      if (m_ctrl) br_n++;
      if (ef) mis_n++;
    end
    if (!stall) begin
      m_valid = in_valid && !ef;
      if (m_valid) begin
        ref_resolve(opfunct, rs1_val, rs2_val, pc, imm, m_ctrl, m_cond, m_ill, m_taken, m_redir);
        m_pred = pred_taken;
        m_idx  = int'(pc[5:2]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  logic [2:0] valid_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  int         exp_lk [7] = '{0, 0, 1, 1, 1, 1, 0};

  initial begin
    int b0;
    logic [31:0] r, a;
    model_reset();
    #2;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_redirect", redirect_pc, 0);
    check_val("rst_br_count", br_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // BEQ mispredicted not-taken; the instruction behind it is dropped
    drive(1, {3'b000, OPB}, 32'h1234, 32'h1234, 32'h100, 32'h20, 0, 0, 32'h100);
    step();
    drive(1, {3'b000, OPJ}, 0, 0, 32'h104, 32'h8, 1, 0, 32'h100);
    sample();
    check_val("beq_taken", taken, 1);
    check_val("beq_flush", flush, 1);
    check_val("beq_redirect", redirect_pc, 32'h120);
    advance();
    idle(32'h100);
    sample();
    check_val("beq_drop", out_valid, 0);
    check_val("beq_mispred", mispred_count, 1);
    advance();

    // signed vs unsigned less-than on the same operands
    drive(1, {3'b100, OPB}, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 0, 0, 32'h0);
    step();
    idle(32'h0);
    sample();
    check_val("blt_taken", taken, 1);
    check_val("blt_flush", flush, 1);
    check_val("blt_redirect", redirect_pc, 32'h340);
    advance();
    drive(1, {3'b110, OPB}, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 0, 0, 32'h0);
    step();
    idle(32'h0);
    sample();
    check_val("bltu_valid", out_valid, 1);
    check_val("bltu_taken", taken, 0);
    check_val("bltu_flush", flush, 0);
    advance();

    // JALR: correctly predicted, then mispredicted to expose the target
    drive(1, {3'b000, OPJR}, 32'h1001, 32'h0, 32'h400, 32'h4, 1, 0, 32'h408);
    step();
    drive(1, {3'b000, OPJR}, 32'h1001, 32'h0, 32'h404, 32'h4, 0, 0, 32'h408);
    sample();
    check_val("jalr_taken", taken, 1);
    check_val("jalr_noflush", flush, 0);
    advance();
    idle(32'h408);
    sample();
    check_val("jalr_target", redirect_pc, 32'h1004);
    check_val("jalr_bht", lookup_taken, 0);
    advance();

    // BHT training on one BNE: three taken, two not-taken, looked up each cycle
    for (int k = 0; k < 7; k++) begin
      if (k < 3)      drive(1, {3'b001, OPB}, 32'h1, 32'h2, 32'h204, 32'h10, 1, 0, 32'h204);
      else if (k < 5) drive(1, {3'b001, OPB}, 32'h7, 32'h7, 32'h204, 32'h10, 0, 0, 32'h204);
      else            idle(32'h204);
      sample();
      check_val("bht_train", lookup_taken, exp_lk[k]);
      advance();
    end

    // stall holds a mispredicted BGE; flush only after release
    drive(1, {3'b101, OPB}, 32'h5, 32'h3, 32'h500, 32'h10, 0, 0, 32'h500);
    step();
    b0 = br_n;
    for (int k = 0; k < 3; k++) begin
      drive(1, {3'b000, OPJ}, 0, 0, 32'h600, 32'h4, 0, 1, 32'h500);
      sample();
      check_val("stall_noflush", flush, 0);
      advance();
    end
    idle(32'h500);
    sample();
    check_val("stall_release_flush", flush, 1);
    check_val("stall_redirect", redirect_pc, 32'h510);
    advance();
    sample();
    check_val("stall_once", br_count, b0 + 1);
    check_val("stall_flush_off", flush, 0);
    advance();

    // reserved branch funct3
    drive(1, {3'b010, OPB}, 32'h9, 32'h9, 32'h700, 32'h10, 0, 0, 32'h700);
    step();
    idle(32'h700);
    sample();
    check_val("illegal_flag", illegal_br, 1);
    check_val("illegal_taken", taken, 0);
    advance();

    // asynchronous reset in the middle of a flush
    drive(1, {3'b000, OPAL}, 32'h1, 32'h2, 32'h30C, 32'h0, 1, 0, 32'h0);
    step();
    idle(32'h0);
    sample();
    check_val("pre_reset_flush", flush, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_flush", flush, 0);
    check_val("mid_rst_taken", taken, 0);
    check_val("mid_rst_illegal", illegal_br, 0);
    check_val("mid_rst_redirect", redirect_pc, 0);
    check_val("mid_rst_br_count", br_count, 0);
    check_val("mid_rst_mispred", mispred_count, 0);
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i * 4);
      #1;
      check_val("mid_rst_bht", lookup_taken, 0);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int kind;
      logic [9:0]  of;
      logic [31:0] b, p;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3, 4, 5: of = {valid_f3[$urandom_range(0, 5)], OPB};
        6:                of = {3'($urandom_range(0, 7)), OPJ};
        7:                of = {($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7)), OPJR};
        8:                of = 10'($urandom);
        default:          of = {($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011, OPB};
      endcase
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom;
        2:       b = a + ((($urandom_range(0, 1)) == 0) ? 32'd1 : 32'hFFFF_FFFF);
        default: b = a ^ 32'h8000_0000;
      endcase
      r = $urandom;
      p = 32'h1000 + 32'($urandom_range(0, 31) * 4);
      drive(($urandom_range(0, 4) != 0), of, a, b, p, {{20{r[11]}}, r[11:1], 1'b0},
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 1) == 0) ? p : 32'h1000 + 32'($urandom_range(0, 15) * 4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
